coax_tx_ss_generator: RTL
=========================

Name: coax_tx_ss_generator

Overview:
- Transmit-side counterpart of the coax receive start-sequence detector.
- On request, drives the 3270 coax start sequence onto the serial line: 5 Manchester "1" pulses (line quiesce), then the 3-bit line code violation.
- Sits between the transmit controller and the line driver. The word serializer starts its sync bit on this block's done strobe.
- Generated timing sits mid-window of every receiver check, so a looped-back line strobes the detector exactly once.

Parameters:
- CLOCKS_PER_BIT, 8: clk cycles per bit cell. Must be even and >= 4; the bench checks this at elaboration.
- PULSE_COUNT, 5: quiesce pulses before the code violation. Shared constant; the receiver uses the same value.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- enable  input  1  low forces IDLE, identical to reset.
- start  input  1  request; sampled only when ready=1.
- ready  output  1  high in IDLE; start accepted only while high.
- tx  output  1  serial line level (registered).
- tx_active  output  1  line driver enable (registered).
- done  output  1  one-cycle strobe at the end of the code violation (registered).

Behaviour:
- Reset/enable low: state=IDLE, tx=0, tx_active=0, done=0, ready=1, counters=0. Takes effect at the next posedge. No done is emitted for an aborted sequence. Reset overrides enable and start.
- Let H = CLOCKS_PER_BIT/2 and V = 3*CLOCKS_PER_BIT/2.
- Counters:
  - bit_timer: width $clog2(V)+1, counts down, reloaded on each state entry.
  - pulse_counter: width $clog2(PULSE_COUNT)+1.
- IDLE:
  - ready=1, tx=0, tx_active=0.
  - start=1 at edge N: go to PULSE_HIGH, pulse_counter=1.
  - tx=1, tx_active=1 and ready=0 are visible from cycle N+1.
- PULSE_HIGH:
  - tx=1 for exactly H cycles, then go to PULSE_LOW.
- PULSE_LOW:
  - tx=0 for H cycles.
  - At expiry: if pulse_counter==PULSE_COUNT, go to CV_LOW. Otherwise increment pulse_counter and go to PULSE_HIGH.
- CV_LOW:
  - tx=0 for a further CLOCKS_PER_BIT cycles.
  - The line is therefore low for V cycles after the 5th falling edge.
- CV_HIGH:
  - tx=1 for V cycles.
  - At expiry: go to DONE.
- DONE:
  - Lasts one cycle: tx=0, tx_active=1, done=1.
  - Next cycle: IDLE (tx_active=0, ready=1).
- Timing, CLOCKS_PER_BIT=8, relative to the first tx=1 cycle (cycle 0):
  - Falling edges at cycles 4, 12, 20, 28, 36.
  - Rising edge at 48; final falling edge with done=1 at 60.
  - Total sequence is 61 cycles including DONE.
- Rise and fall fall inside the receiver windows:
  - Rise at 1.5 bits after the last pulse edge (window >1 and <=2).
  - Fall at 3.0 bits (window >2.5 and <=3.5).
- Start handling:
  - start while ready=0 is ignored; no queuing.
  - start held high continuously gives back-to-back sequences with exactly one IDLE cycle (tx=0) between DONE and the next PULSE_HIGH.
- No glitches: tx changes only at state boundaries, with at most one transition per cycle.

Decomposition:
- Shared include (coax_ss_params.vh), used by this block and the receive detector: PULSE_COUNT, and derived localparams for the 1.5/2/2.5/3.5-bit windows expressed in CLOCKS_PER_BIT.
- State encoding (IDLE, PULSE_HIGH, PULSE_LOW, CV_LOW, CV_HIGH, DONE; 3 bits) stays local.
- No sub-module; one FSM plus two counters.

Test Plan:
- CLOCKS_PER_BIT=8, single start pulse:
  - tx is high 4 / low 4, five times, then low 12, high 12, then falls.
  - done=1 only at relative cycle 60.
  - tx_active high for cycles 0..60; ready low for exactly 61 cycles.
- Loopback into coax_rx_ss_detector (enable=1), same CLOCKS_PER_BIT:
  - Exactly one detector strobe per sequence, 1–2 cycles after the final falling edge.
  - No strobe during the quiesce pulses.
- start held high for 200 cycles:
  - Three complete sequences, each separated by one IDLE cycle.
  - Three done strobes, 62 cycles apart.
- Reset driven 0 at relative cycle 30 (mid pulse 4):
  - Next cycle: tx=0, tx_active=0, ready=1.
  - No done.
  - A fresh start afterwards yields a full, correct sequence.
- enable dropped at relative cycle 50 (CV_HIGH):
  - Same abort behaviour as reset.
  - A start while enable=0 is ignored.
- CLOCKS_PER_BIT=16:
  - Falling edges at 8, 24, 40, 56, 72; rise at 96; done at 120.
  - Loopback detector strobes once.

Source files
------------

// File: rtl/coax_tx_ss_generator_pkg.sv
// Shared coax start-sequence constants and the bit-window helpers used by the
// transmit generator and the receive detector.
package coax_tx_ss_generator_pkg;

    localparam int unsigned PULSE_COUNT = 5;

    function automatic int unsigned ss_half_bit(input int unsigned cpb);
        return cpb / 2;
    endfunction

    function automatic int unsigned ss_win_1p5(input int unsigned cpb);
        return (3 * cpb) / 2;
    endfunction

    function automatic int unsigned ss_win_2(input int unsigned cpb);
        return 2 * cpb;
    endfunction

    function automatic int unsigned ss_win_2p5(input int unsigned cpb);
        return (5 * cpb) / 2;
    endfunction

    function automatic int unsigned ss_win_3p5(input int unsigned cpb);
        return (7 * cpb) / 2;
    endfunction

endpackage

// File: rtl/coax_tx_ss_generator.sv
// Drives the 3270 coax start sequence: PULSE_COUNT Manchester "1" pulses,
// then the low/high line code violation, closed by a one-cycle done strobe.
module coax_tx_ss_generator
    import coax_tx_ss_generator_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic start,
    output logic ready,
    output logic tx,
    output logic tx_active,
    output logic done
);

    localparam int unsigned H  = ss_half_bit(CLOCKS_PER_BIT);
    localparam int unsigned V  = ss_win_1p5(CLOCKS_PER_BIT);
    localparam int unsigned TW = $clog2(V) + 1;
    localparam int unsigned PW = $clog2(PULSE_COUNT) + 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PULSE_HIGH = 3'd1,
        S_PULSE_LOW  = 3'd2,
        S_CV_LOW     = 3'd3,
        S_CV_HIGH    = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_bit_timer;
    logic [PW-1:0]   r_pulse_cnt;
    logic            r_tx;
    logic            r_tx_active;
    logic            r_done;
    logic            r_ready;

    logic            w_expired;
    assign w_expired = (r_bit_timer == '0);

    // Outputs are set alongside each state transition so they line up with the new state.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            r_state     <= S_IDLE;
            r_bit_timer <= '0;
            r_pulse_cnt <= '0;
            r_tx        <= 1'b0;
            r_tx_active <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_PULSE_HIGH;
                        r_pulse_cnt <= PW'(1);
                        r_bit_timer <= TW'(H - 1);
                        r_tx        <= 1'b1;
                        r_tx_active <= 1'b1;
                        r_ready     <= 1'b0;
                    end
                end
                S_PULSE_HIGH: begin
                    if (w_expired) begin
                        r_state     <= S_PULSE_LOW;
                        r_bit_timer <= TW'(H - 1);
                        r_tx        <= 1'b0;
                    end else begin
                        r_bit_timer <= r_bit_timer - TW'(1);
                    end
                end
                S_PULSE_LOW: begin
                    if (w_expired) begin
                        if (r_pulse_cnt == PW'(PULSE_COUNT)) begin
                            r_state     <= S_CV_LOW;
                            r_bit_timer <= TW'(CLOCKS_PER_BIT - 1);
                        end else begin
                            r_state     <= S_PULSE_HIGH;
                            r_pulse_cnt <= r_pulse_cnt + PW'(1);
                            r_bit_timer <= TW'(H - 1);
                            r_tx        <= 1'b1;
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer - TW'(1);
                    end
                end
                S_CV_LOW: begin
                    if (w_expired) begin
                        r_state     <= S_CV_HIGH;
                        r_bit_timer <= TW'(V - 1);
                        r_tx        <= 1'b1;
                    end else begin
                        r_bit_timer <= r_bit_timer - TW'(1);
                    end
                end
                S_CV_HIGH: begin
                    if (w_expired) begin
                        r_state     <= S_DONE;
                        r_bit_timer <= '0;
                        r_tx        <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_bit_timer <= r_bit_timer - TW'(1);
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_bit_timer <= '0;
                    r_pulse_cnt <= '0;
                    r_tx_active <= 1'b0;
                    r_ready     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_bit_timer <= '0;
                    r_pulse_cnt <= '0;
                    r_tx        <= 1'b0;
                    r_tx_active <= 1'b0;
                    r_ready     <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign tx        = r_tx;
    assign tx_active = r_tx_active;
    assign done      = r_done;

endmodule
